sim_echo_ep_consumer: RTL

Simulation-only endpoint consumer that sits on the device-side endpoint interface of the USB device top, in the slot driven by the top-level EP consumer macro.
- Pops each complete packet the host sent to one non-control endpoint (EP_IN_* side, device-centric naming).
- Buffers the packet locally, then pushes it back into the same endpoint's EP_OUT_* buffer so the host imitator reads back an echo.
- Single packet in flight; strictly store-and-forward.

---
 rtl/sim_echo_ep_consumer_pkg.sv | 25 ++
 rtl/sim_echo_ep_consumer_pkt_buf.sv | 23 ++
 rtl/sim_echo_ep_consumer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sim_echo_ep_consumer_pkg.sv
// Shared types, constants and byte transform for the simulation echo consumer.
// SIM_ECHO_INCREMENT_EN: when defined, echoed bytes are returned as value + 1.
package sim_echo_ep_consumer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    READ_DONE,
    WRITE,
    WRITE_DONE,
    DROP
  } EchoState_t;

  localparam int SIM_ECHO_DEFAULT_DEPTH = 64;

  // A +1 transform makes a real echo distinguishable from a wiring loopback.
  function automatic logic [7:0] echoXform(input logic [7:0] b);
`ifdef SIM_ECHO_INCREMENT_EN
    return b + 8'd1;
`else
    return b;
`endif
  endfunction

endpackage

// File: rtl/sim_echo_ep_consumer_pkt_buf.sv
// Packet store for the echo consumer: synchronous write, combinational read.
module sim_echo_pkt_buf #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sim_echo_ep_consumer.sv
// Simulation endpoint consumer: pops a whole received packet, then echoes it back.
// SIM_ECHO_INCREMENT_EN: when defined, each echoed byte is stored value + 1.
module sim_echo_ep_consumer
  import sim_echo_ep_consumer_pkg::*;
#(
  parameter int BUF_DEPTH = SIM_ECHO_DEFAULT_DEPTH,
  parameter int CNT_W     = 16
) (
  input  logic             clk12_i,
  input  logic             rst_i,
  input  logic             EP_IN_dataAvailable_i,
  input  logic [7:0]       EP_IN_data_i,
  output logic             EP_IN_popData_o,
  output logic             EP_IN_popTransDone_o,
  output logic             EP_IN_popTransSuccess_o,
  input  logic             EP_OUT_full_i,
  output logic             EP_OUT_dataValid_o,
  output logic [7:0]       EP_OUT_data_o,
  output logic             EP_OUT_fillTransDone_o,
  output logic             EP_OUT_fillTransSuccess_o,
  output logic [CNT_W-1:0] echoCount_o,
  output logic             overflow_o
);

  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(BUF_DEPTH);

  EchoState_t       state_reg, state_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;

  logic       pop, pop_done, fill_valid, fill_done, buf_we;
  logic [7:0] rd_data;

  sim_echo_pkt_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk12_i),
    .we      (buf_we),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_data (EP_IN_data_i),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    pop_done   = 1'b0;
    fill_valid = 1'b0;
    fill_done  = 1'b0;
    buf_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (EP_IN_dataAvailable_i) state_next = READ;
      end
      READ: begin
        pop = EP_IN_dataAvailable_i;
        if (EP_IN_dataAvailable_i) begin
          // A byte still arriving once the buffer holds BUF_DEPTH means the packet is too long.
          if (wr_ptr_reg == FULL_PTR) state_next = DROP;
          else                        buf_we     = 1'b1;
        end else if (wr_ptr_reg != '0) begin
          state_next = READ_DONE;
        end
      end
      READ_DONE: begin
        pop_done   = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        fill_valid = 1'b1;
        if (!EP_OUT_full_i && (rd_ptr_reg + PTR_W'(1) == wr_ptr_reg)) state_next = WRITE_DONE;
      end
      WRITE_DONE: begin
        fill_done  = 1'b1;
        state_next = IDLE;
      end
      DROP: begin
        pop = EP_IN_dataAvailable_i;
        if (!EP_IN_dataAvailable_i) begin
          pop_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (buf_we) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (fill_valid && !EP_OUT_full_i) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (fill_done) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= count_reg + CNT_W'(1);
      end
      if (state_reg == DROP && pop_done) begin
        overflow_reg <= 1'b1;
        wr_ptr_reg   <= '0;
      end
    end
  end

  assign EP_IN_popData_o           = pop;
  assign EP_IN_popTransDone_o      = pop_done;
  assign EP_IN_popTransSuccess_o   = pop_done;
  assign EP_OUT_dataValid_o        = fill_valid;
  assign EP_OUT_data_o             = fill_valid ? echoXform(rd_data) : 8'h00;
  assign EP_OUT_fillTransDone_o    = fill_done;
  assign EP_OUT_fillTransSuccess_o = fill_done;
  assign echoCount_o               = count_reg;
  assign overflow_o                = overflow_reg;

endmodule
